bit_serializer: RTL
===================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter: WIDTH, default 8, number of bits per parallel word (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: din  input  WIDTH  parallel word to serialize.
REQ-005 Port: din_valid  input  1  din holds a word offered for transfer.
REQ-006 Port: din_ready  output  1  block can accept a word this cycle.
REQ-007 Port: sout  output  1  serial data bit, MSB first, directly drivable into the serial remainder-checker input.
REQ-008 Port: sout_valid  output  1  sout carries a word bit this cycle.
REQ-009 Port: sout_last  output  1  sout carries bit 0 (LSB) of the current word.
REQ-010 Port: busy  output  1  a word is being shifted or is buffered.

Function
REQ-011 The block SHALL contain a one-entry holding buffer (buf, buf_full), a WIDTH-bit shift register, a down-counter cnt, and a two-state FSM: IDLE and SHIFT.
REQ-012 din_ready SHALL equal !buf_full, driven from registers only, with no combinational path from din_valid.
REQ-013 A transfer SHALL occur at a rising edge where din_valid=1 and din_ready=1; din SHALL be captured into buf and buf_full SHALL be set.
REQ-014 din_valid while din_ready=0 SHALL be ignored, with no capture and no state change.
REQ-015 IDLE with buf_full=1 at an edge: load shift register from buf, set cnt=WIDTH-1, clear buf_full, go to SHIFT.
REQ-016 IDLE with buf_full=0: remain in IDLE.
REQ-017 SHIFT with cnt!=0 at an edge: shift the register left by one (zero fill) and decrement cnt.
REQ-018 SHIFT with cnt=0 and buf_full=1: reload from buf, set cnt=WIDTH-1, clear buf_full, stay in SHIFT (no idle gap between words).
REQ-019 SHIFT with cnt=0 and buf_full=0: go to IDLE.
REQ-020 sout SHALL equal shift register MSB when in SHIFT, and 0 otherwise.
REQ-021 sout_valid SHALL be 1 exactly when in SHIFT.
REQ-022 sout_last SHALL be 1 exactly when in SHIFT and cnt=0.
REQ-023 busy SHALL equal (state==SHIFT) OR buf_full.
REQ-024 Latency: a word accepted at edge k SHALL present its MSB on sout after edge k+1 if the block was IDLE, and its LSB with sout_last after edge k+WIDTH.
REQ-025 A word accepted during SHIFT SHALL wait in buf and start immediately after the current word's sout_last cycle.
REQ-026 Each word SHALL occupy exactly WIDTH consecutive sout_valid cycles.
REQ-027 Words SHALL be emitted in acceptance order, never dropped or duplicated.
REQ-028 A reload edge (REQ-015 or REQ-018) SHALL not accept a new word on the same edge, because din_ready was 0 during that cycle.
REQ-029 din_ready SHALL rise in the cycle after the reload.

Reset
REQ-030 While rst=1, regardless of clk: state=IDLE, buf_full=0, cnt=0, shift register=0, buf=0.
REQ-031 Outputs during and after reset: din_ready=1, sout=0, sout_valid=0, sout_last=0, busy=0.
REQ-032 Reset asserted mid-word SHALL discard both the word being shifted and the buffered word.
REQ-033 The first edge after rst deasserts SHALL behave as IDLE with an empty buffer.

Verification
REQ-034 WIDTH=8, from idle, accept din=8'hA5 -> sout 1,0,1,0,0,1,0,1 on 8 consecutive valid cycles starting after the next edge; sout_last only on the 8th; then sout_valid=0 and busy=0.
REQ-035 Back-to-back: accept 8'h0F, then 8'hF0 at the first din_ready -> 16 contiguous sout_valid cycles with sout 0000111111110000 and sout_last on cycles 8 and 16.
REQ-036 Stall: din_valid held high with three different words -> the second word is held while buf is full (din_ready=0); all three words are emitted in order with no loss.
REQ-037 Ignored offer: din_valid=1 while din_ready=0 with din=8'hFF, then valid dropped -> no 8'hFF appears on sout.
REQ-038 Reset mid-word: assert rst after the 3rd bit of 8'hC3 with 8'h81 buffered -> all outputs go to reset values immediately; after release, no bits of either word are emitted.
REQ-039 WIDTH=2 corner: accept 2'b10 twice back-to-back -> sout 1,0,1,0 contiguous, with sout_last on cycles 2 and 4.

Source files
------------

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: one-entry holding buffer feeding a WIDTH-bit
// shift register, MSB first, with back-to-back reload and no idle gap.
module bit_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_buf;
    logic             r_buf_full;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;

    logic w_accept;
    logic w_load;
    logic w_shift;
    logic w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);
    // Accept and load are mutually exclusive: load needs a full buffer, accept an empty one.
    assign w_accept   = din_valid && !r_buf_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_buf_full) begin
                    w_load       = 1'b1;
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (!w_cnt_zero) begin
                    w_shift = 1'b1;
                end else if (r_buf_full) begin
                    w_load = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf      <= '0;
            r_buf_full <= 1'b0;
        end else if (w_load) begin
            r_buf_full <= 1'b0;
        end else if (w_accept) begin
            r_buf      <= din;
            r_buf_full <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_shift <= r_buf;
            r_cnt   <= CW'(WIDTH - 1);
        end else if (w_shift) begin
            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            r_cnt   <= r_cnt - CW'(1);
        end
    end

    assign din_ready  = !r_buf_full;
    assign sout_valid = (r_state == SHIFT);
    assign sout       = (r_state == SHIFT) && r_shift[WIDTH-1];
    assign sout_last  = (r_state == SHIFT) && w_cnt_zero;
    assign busy       = (r_state == SHIFT) || r_buf_full;

endmodule
